iir_out_requant: RTL and testbench

IIR_OUT_REQUANT -- requirements
Module: iir_out_requant

---
 rtl/iir_out_requant.sv | 123 ++++++++++++
 tb/tb_iir_out_requant.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/iir_out_requant.sv
// rtl/iir_out_requant.sv - requantize wide IIR samples to OW bits with saturation stats
// Two-entry skid FIFO on the output; saturation counter and sticky flag.
module iir_out_requant #(
  parameter int IW    = 18,
  parameter int SHIFT = 6,
  parameter int OW    = 8,
  parameter     ROUND = "TRUE",
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IW-1:0]    axis_i_tdata,
  input  logic             axis_i_tvalid,
  output logic             axis_i_tready,
  output logic [OW-1:0]    axis_o_tdata,
  output logic             axis_o_tvalid,
  input  logic             axis_o_tready,
  input  logic             sat_clear,
  output logic [CNT_W-1:0] sat_count,
  output logic             sat_sticky
);

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_t;

  localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic [IW:0] RND =
    ((ROUND == "TRUE") && (SHIFT > 0)) ? ({{IW{1'b0}}, 1'b1} << RSH) : '0;

  state_t            state_q, state_d;
  logic              tready_q;
  logic [OW-1:0]     data0_q, data0_d;
  logic [OW-1:0]     data1_q, data1_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sticky_q, sticky_d;

  logic [IW:0]        t_w;
  logic signed [IW:0] y_w;
  logic               in_range_w;
  logic [OW-1:0]      q_w;
  logic               accept_w, emit_w, sat_evt_w;

  // One extra bit of headroom so the rounding offset cannot overflow.
  assign t_w = {axis_i_tdata[IW-1], axis_i_tdata} + RND;
  assign y_w = $signed(t_w) >>> SHIFT;

  // In range exactly when every bit from the output sign bit upward agrees.
  assign in_range_w = (&y_w[IW:OW-1]) | ~(|y_w[IW:OW-1]);
  assign q_w = in_range_w ? y_w[OW-1:0] :
               (y_w[IW] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}});

  assign accept_w  = axis_i_tvalid & tready_q;
  assign emit_w    = (state_q != S_EMPTY) & axis_o_tready;
  assign sat_evt_w = accept_w & ~in_range_w;

  always_comb begin
    state_d = state_q;
    data0_d = data0_q;
    data1_d = data1_q;
    case (state_q)
      S_EMPTY: begin
        if (accept_w) begin
          data0_d = q_w;
          state_d = S_ONE;
        end
      end
      S_ONE: begin
        if (accept_w && emit_w) begin
          data0_d = q_w;
        end else if (accept_w) begin
          data1_d = q_w;
          state_d = S_FULL;
        end else if (emit_w) begin
          state_d = S_EMPTY;
        end
      end
      S_FULL: begin
        if (emit_w) begin
          data0_d = data1_q;
          state_d = S_ONE;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  // Clear wins over history but not over an event landing in the same cycle.
  always_comb begin
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    if (sat_clear) begin
      cnt_d    = sat_evt_w ? {{(CNT_W-1){1'b0}}, 1'b1} : '0;
      sticky_d = sat_evt_w;
    end else if (sat_evt_w) begin
      sticky_d = 1'b1;
      if (!(&cnt_q)) cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_EMPTY;
      tready_q <= 1'b0;
      data0_q  <= '0;
      data1_q  <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      tready_q <= (state_d != S_FULL);
      data0_q  <= data0_d;
      data1_q  <= data1_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
    end
  end

  assign axis_i_tready = tready_q;
  assign axis_o_tvalid = (state_q != S_EMPTY);
  assign axis_o_tdata  = data0_q;
  assign sat_count     = cnt_q;
  assign sat_sticky    = sticky_q;

endmodule

// File: tb/tb_iir_out_requant.sv
// tb/tb_iir_out_requant.sv - directed self-checking bench for iir_out_requant
module tb_iir_out_requant;

  logic        clk;
  logic        rst_n;
  logic [17:0] axis_i_tdata;
  logic        axis_i_tvalid;
  logic        axis_i_tready;
  logic [7:0]  axis_o_tdata;
  logic        axis_o_tvalid;
  logic        axis_o_tready;
  logic        sat_clear;
  logic [15:0] sat_count;
  logic        sat_sticky;

  logic        c3_i_tready;
  logic [7:0]  c3_o_tdata;
  logic        c3_o_tvalid;
  logic [2:0]  c3_sat_count;
  logic        c3_sat_sticky;

  int n_cmp = 0;
  int n_err = 0;

  iir_out_requant dut (
    .clk(clk), .rst_n(rst_n),
    .axis_i_tdata(axis_i_tdata), .axis_i_tvalid(axis_i_tvalid), .axis_i_tready(axis_i_tready),
    .axis_o_tdata(axis_o_tdata), .axis_o_tvalid(axis_o_tvalid), .axis_o_tready(axis_o_tready),
    .sat_clear(sat_clear), .sat_count(sat_count), .sat_sticky(sat_sticky)
  );

  iir_out_requant #(.CNT_W(3)) dut_c3 (
    .clk(clk), .rst_n(rst_n),
    .axis_i_tdata(axis_i_tdata), .axis_i_tvalid(axis_i_tvalid), .axis_i_tready(c3_i_tready),
    .axis_o_tdata(c3_o_tdata), .axis_o_tvalid(c3_o_tvalid), .axis_o_tready(axis_o_tready),
    .sat_clear(sat_clear), .sat_count(c3_sat_count), .sat_sticky(c3_sat_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic signed [31:0] exp);
    chk({tag, "_valid"}, axis_o_tvalid, 1);
    chk({tag, "_data"}, $signed(axis_o_tdata), exp);
  endtask

  initial begin
    rst_n = 1'b0;
    axis_i_tdata = '0;
    axis_i_tvalid = 1'b0;
    axis_o_tready = 1'b1;
    sat_clear = 1'b0;

    // reset state
    tick();
    tick();
    chk("rst_o_tvalid", axis_o_tvalid, 0);
    chk("rst_i_tready", axis_i_tready, 0);
    chk("rst_o_tdata", axis_o_tdata, 0);
    chk("rst_sat_count", sat_count, 0);
    chk("rst_sat_sticky", sat_sticky, 0);
    rst_n = 1'b1;
    chk("rel_i_tready_pre", axis_i_tready, 0);
    tick();
    chk("rel_i_tready_post", axis_i_tready, 1);

    // rounding, full rate
    axis_i_tvalid = 1'b1;
    axis_i_tdata = 18'(100);   tick(); chk_out("rnd0", 2);
    axis_i_tdata = 18'(-96);   tick(); chk_out("rnd1", -1);
    axis_i_tdata = 18'(95);    tick(); chk_out("rnd2", 1);
    axis_i_tdata = 18'(-33);   tick(); chk_out("rnd3", -1);
    axis_i_tvalid = 1'b0;
    tick();
    chk("rnd_drain_valid", axis_o_tvalid, 0);
    chk("rnd_sat_count", sat_count, 0);
    chk("rnd_sat_sticky", sat_sticky, 0);

    // saturation
    axis_i_tvalid = 1'b1;
    axis_i_tdata = 18'(8191);    tick(); chk_out("sat0", 127);
    axis_i_tdata = 18'(-131072); tick(); chk_out("sat1", -128);
    axis_i_tdata = 18'(8159);    tick(); chk_out("sat2", 127);
    axis_i_tvalid = 1'b0;
    tick();
    chk("sat_count", sat_count, 2);
    chk("sat_sticky", sat_sticky, 1);

    // backpressure: outputs 1,2,3,4
    axis_o_tready = 1'b0;
    axis_i_tvalid = 1'b1;
    axis_i_tdata = 18'(64);  tick();
    chk("bp_e1_ready", axis_i_tready, 1);
    chk_out("bp_e1", 1);
    axis_i_tdata = 18'(128); tick();
    chk("bp_e2_ready", axis_i_tready, 0);
    chk_out("bp_e2", 1);
    axis_i_tdata = 18'(192); tick();
    chk("bp_e3_ready", axis_i_tready, 0);
    chk_out("bp_e3_hold", 1);
    axis_o_tready = 1'b1;
    tick();
    chk("bp_e4_ready", axis_i_tready, 1);
    chk_out("bp_e4", 2);
    tick();
    chk_out("bp_e5", 3);
    axis_i_tdata = 18'(256); tick();
    chk_out("bp_e6", 4);
    axis_i_tvalid = 1'b0;
    tick();
    chk("bp_drain_valid", axis_o_tvalid, 0);

    // clear colliding with a saturation event, then clear alone
    sat_clear = 1'b1;
    axis_i_tvalid = 1'b1;
    axis_i_tdata = 18'(8191);
    tick();
    chk("clr_hit_count", sat_count, 1);
    chk("clr_hit_sticky", sat_sticky, 1);
    chk_out("clr_hit_out", 127);
    axis_i_tvalid = 1'b0;
    tick();
    chk("clr_only_count", sat_count, 0);
    chk("clr_only_sticky", sat_sticky, 0);
    chk("clr_only_c3_count", c3_sat_count, 0);
    sat_clear = 1'b0;

    // counter ceiling: 10 saturating samples
    axis_i_tvalid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      axis_i_tdata = (i % 2 == 0) ? 18'(8191) : 18'(-131072);
      tick();
    end
    axis_i_tvalid = 1'b0;
    tick();
    chk("ceil_count16", sat_count, 10);
    chk("ceil_count3", c3_sat_count, 7);
    chk("ceil_sticky3", c3_sat_sticky, 1);

    // refused input does not count; buffer ends FULL
    sat_clear = 1'b1;
    tick();
    sat_clear = 1'b0;
    axis_o_tready = 1'b0;
    axis_i_tvalid = 1'b1;
    axis_i_tdata = 18'(8191);
    for (int i = 0; i < 4; i++) tick();
    chk("refuse_count", sat_count, 2);
    chk("full_ready", axis_i_tready, 0);
    chk("full_valid", axis_o_tvalid, 1);

    // mid-stream reset with buffer FULL
    axis_i_tvalid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", axis_o_tvalid, 0);
    chk("mid_rst_ready", axis_i_tready, 0);
    chk("mid_rst_data", axis_o_tdata, 0);
    chk("mid_rst_count", sat_count, 0);
    tick();
    rst_n = 1'b1;
    axis_o_tready = 1'b1;
    tick();
    chk("mid_rel_ready", axis_i_tready, 1);
    chk("mid_rel_valid", axis_o_tvalid, 0);
    tick();
    chk("mid_rel_valid2", axis_o_tvalid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
